// File: rtl/gpio_key_input.sv
// Board key front end: 2-flop sync, polarity normalize, per-key debounce, sticky event flags, level irq.
// Optional long-press detection is built when KEY_LONG_PRESS_EN is defined.
module gpio_key_input #(
  parameter int unsigned KEY_NUM         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned KEY_ACTIVE_LOW  = 1,
  parameter int unsigned LONG_CYCLES     = 50000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_NUM-1:0] key_in,
  input  logic [KEY_NUM-1:0] pend_clr,
  input  logic [KEY_NUM-1:0] irq_en,
  output logic [KEY_NUM-1:0] key_state,
  output logic [KEY_NUM-1:0] press_pend,
  output logic [KEY_NUM-1:0] release_pend,
  output logic [KEY_NUM-1:0] long_pend,
  output logic               irq
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [KEY_NUM-1:0] IDLE_PIN = (KEY_ACTIVE_LOW != 0) ? {KEY_NUM{1'b1}} : {KEY_NUM{1'b0}};

  if (KEY_NUM < 1 || KEY_NUM > 32 || DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 1) begin : g_bad_param
    $error("gpio_key_input: illegal parameter value");
  end

  logic [KEY_NUM-1:0] sync1_q, sync2_q;
  logic [KEY_NUM-1:0] pressed;
  logic [CNT_W-1:0]   cnt_q [KEY_NUM];
  logic [CNT_W-1:0]   cnt_d [KEY_NUM];
  logic [KEY_NUM-1:0] key_state_q, key_state_d;
  logic [KEY_NUM-1:0] press_pend_q, press_pend_d;
  logic [KEY_NUM-1:0] release_pend_q, release_pend_d;
  logic [KEY_NUM-1:0] long_pend_q;
  logic               irq_q, irq_d;

  // Debounce: toggle only after DEBOUNCE_CYCLES consecutive mismatching samples.
  always_comb begin
    pressed     = sync2_q ^ IDLE_PIN;
    key_state_d = key_state_q;
    for (int i = 0; i < int'(KEY_NUM); i++) begin
      cnt_d[i] = '0;
      if (pressed[i] != key_state_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          key_state_d[i] = ~key_state_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    press_pend_d   = (press_pend_q & ~pend_clr) | (key_state_d & ~key_state_q);
    release_pend_d = (release_pend_q & ~pend_clr) | (~key_state_d & key_state_q);
    irq_d          = |((press_pend_q | release_pend_q | long_pend_q) & irq_en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q        <= IDLE_PIN;
      sync2_q        <= IDLE_PIN;
      key_state_q    <= '0;
      press_pend_q   <= '0;
      release_pend_q <= '0;
      irq_q          <= 1'b0;
      for (int i = 0; i < int'(KEY_NUM); i++) cnt_q[i] <= '0;
    end else begin
      sync1_q        <= key_in;
      sync2_q        <= sync1_q;
      key_state_q    <= key_state_d;
      press_pend_q   <= press_pend_d;
      release_pend_q <= release_pend_d;
      irq_q          <= irq_d;
      for (int i = 0; i < int'(KEY_NUM); i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef KEY_LONG_PRESS_EN
  localparam int unsigned LONG_W = $clog2(LONG_CYCLES + 1);

  logic [LONG_W-1:0]  hold_q [KEY_NUM];
  logic [LONG_W-1:0]  hold_d [KEY_NUM];
  logic [KEY_NUM-1:0] long_set;
  logic [KEY_NUM-1:0] long_pend_d;

  // Hold counter saturates at LONG_CYCLES so each press yields a single long event.
  always_comb begin
    for (int i = 0; i < int'(KEY_NUM); i++) begin
      hold_d[i]   = '0;
      long_set[i] = 1'b0;
      if (key_state_q[i]) begin
        hold_d[i] = hold_q[i];
        if (hold_q[i] != LONG_W'(LONG_CYCLES)) begin
          hold_d[i]   = hold_q[i] + LONG_W'(1);
          long_set[i] = (hold_q[i] == LONG_W'(LONG_CYCLES - 1));
        end
      end
    end
    long_pend_d = (long_pend_q & ~pend_clr) | long_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      long_pend_q <= '0;
      for (int i = 0; i < int'(KEY_NUM); i++) hold_q[i] <= '0;
    end else begin
      long_pend_q <= long_pend_d;
      for (int i = 0; i < int'(KEY_NUM); i++) hold_q[i] <= hold_d[i];
    end
  end
`else
  assign long_pend_q = '0;
`endif

  assign key_state    = key_state_q;
  assign press_pend   = press_pend_q;
  assign release_pend = release_pend_q;
  assign long_pend    = long_pend_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_gpio_key_input.sv
// Directed bench for gpio_key_input: vector table plus hand sequences for clear race, reset and long press.
module tb_gpio_key_input;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_in, pend_clr, irq_en;
  logic [3:0] key_state, press_pend, release_pend, long_pend;
  logic       irq;

  int checks   = 0;
  int failures = 0;

  gpio_key_input #(
    .KEY_NUM(4), .DEBOUNCE_CYCLES(16), .KEY_ACTIVE_LOW(1), .LONG_CYCLES(40)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .pend_clr(pend_clr), .irq_en(irq_en),
    .key_state(key_state), .press_pend(press_pend), .release_pend(release_pend),
    .long_pend(long_pend), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] key;
    logic [3:0] clr;
    logic [3:0] en;
    logic [7:0] cyc;
    logic [3:0] ks;
    logic [3:0] pp;
    logic [3:0] rp;
    logic       irq;
  } vec_t;

  vec_t vecs [25];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] ks, input logic [3:0] pp,
                           input logic [3:0] rp, input logic [3:0] lp, input logic iq);
    check({tag, "_ks"}, 32'(key_state), 32'(ks));
    check({tag, "_pp"}, 32'(press_pend), 32'(pp));
    check({tag, "_rp"}, 32'(release_pend), 32'(rp));
    check({tag, "_lp"}, 32'(long_pend), 32'(lp));
    check({tag, "_irq"}, 32'(irq), 32'(iq));
  endtask

  initial begin
    //             key    clr    en    cyc    ks     pp     rp    irq
    vecs[0]  = '{4'hF, 4'h0, 4'hF, 8'd2,  4'h0, 4'h0, 4'h0, 1'b0};
    vecs[1]  = '{4'hE, 4'h0, 4'hF, 8'd17, 4'h0, 4'h0, 4'h0, 1'b0};
    vecs[2]  = '{4'hE, 4'h0, 4'hF, 8'd1,  4'h1, 4'h1, 4'h0, 1'b0};
    vecs[3]  = '{4'hE, 4'h0, 4'hF, 8'd1,  4'h1, 4'h1, 4'h0, 1'b1};
    vecs[4]  = '{4'hE, 4'h1, 4'hF, 8'd1,  4'h1, 4'h0, 4'h0, 1'b1};
    vecs[5]  = '{4'hE, 4'h0, 4'hF, 8'd1,  4'h1, 4'h0, 4'h0, 1'b0};
    vecs[6]  = '{4'hF, 4'h0, 4'hF, 8'd18, 4'h0, 4'h0, 4'h1, 1'b0};
    vecs[7]  = '{4'hF, 4'h0, 4'hF, 8'd1,  4'h0, 4'h0, 4'h1, 1'b1};
    vecs[8]  = '{4'hF, 4'hF, 4'hF, 8'd2,  4'h0, 4'h0, 4'h0, 1'b0};
    vecs[9]  = '{4'hD, 4'h0, 4'hF, 8'd15, 4'h0, 4'h0, 4'h0, 1'b0};
    vecs[10] = '{4'hF, 4'h0, 4'hF, 8'd10, 4'h0, 4'h0, 4'h0, 1'b0};
    vecs[11] = '{4'hD, 4'h0, 4'hF, 8'd16, 4'h0, 4'h0, 4'h0, 1'b0};
    vecs[12] = '{4'hF, 4'h0, 4'hF, 8'd2,  4'h2, 4'h2, 4'h0, 1'b0};
    vecs[13] = '{4'hF, 4'h0, 4'hF, 8'd15, 4'h2, 4'h2, 4'h0, 1'b1};
    vecs[14] = '{4'hF, 4'h0, 4'hF, 8'd1,  4'h0, 4'h2, 4'h2, 1'b1};
    vecs[15] = '{4'hF, 4'hF, 4'hF, 8'd2,  4'h0, 4'h0, 4'h0, 1'b0};
    vecs[16] = '{4'hB, 4'h0, 4'h1, 8'd18, 4'h4, 4'h4, 4'h0, 1'b0};
    vecs[17] = '{4'hB, 4'h0, 4'h1, 8'd3,  4'h4, 4'h4, 4'h0, 1'b0};
    vecs[18] = '{4'hB, 4'h0, 4'h4, 8'd1,  4'h4, 4'h4, 4'h0, 1'b1};
    vecs[19] = '{4'hB, 4'h0, 4'h0, 8'd1,  4'h4, 4'h4, 4'h0, 1'b0};
    vecs[20] = '{4'hF, 4'hF, 4'hF, 8'd18, 4'h0, 4'h0, 4'h4, 1'b0};
    vecs[21] = '{4'hF, 4'hF, 4'hF, 8'd2,  4'h0, 4'h0, 4'h0, 1'b0};
    vecs[22] = '{4'h0, 4'h0, 4'hF, 8'd18, 4'hF, 4'hF, 4'h0, 1'b0};
    vecs[23] = '{4'hF, 4'hF, 4'hF, 8'd18, 4'h0, 4'h0, 4'hF, 1'b0};
    vecs[24] = '{4'hF, 4'hF, 4'hF, 8'd2,  4'h0, 4'h0, 4'h0, 1'b0};

    rst_n    = 1'b0;
    key_in   = 4'hF;
    pend_clr = 4'h0;
    irq_en   = 4'hF;
    tick(3);
    check_all("reset", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      key_in   = vecs[i].key;
      pend_clr = vecs[i].clr;
      irq_en   = vecs[i].en;
      tick(1);
      pend_clr = 4'h0;
      tick(int'(vecs[i].cyc) - 1);
      check_all($sformatf("vec%0d", i), vecs[i].ks, vecs[i].pp, vecs[i].rp, 4'h0, vecs[i].irq);
    end

    // Clear held across the set edge and the one after: set wins, then clear takes effect.
    key_in = 4'hE;
    tick(17);
    pend_clr = 4'h1;
    tick(1);
    check("race_set_wins_pp", 32'(press_pend), 32'h1);
    check("race_set_wins_irq", 32'(irq), 32'h0);
    tick(1);
    check("race_clear_pp", 32'(press_pend), 32'h0);
    check("race_clear_irq_lag", 32'(irq), 32'h1);
    pend_clr = 4'h0;
    tick(1);
    check("race_irq_drop", 32'(irq), 32'h0);
    key_in = 4'hF;
    tick(18);
    pend_clr = 4'hF;
    tick(1);
    pend_clr = 4'h0;
    tick(2);
    check_all("race_idle", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);

    // Reset in the middle of key3's debounce while key2 is already latched.
    key_in = 4'hB;
    tick(20);
    check("rst_pre_pp", 32'(press_pend), 32'h4);
    check("rst_pre_irq", 32'(irq), 32'h1);
    key_in = 4'h3;
    tick(12);
    rst_n = 1'b0;
    #1;
    check_all("rst_async", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(17);
    check("rst_post17_ks", 32'(key_state), 32'h0);
    tick(1);
    check("rst_post18_ks", 32'(key_state), 32'hC);
    check("rst_post18_pp", 32'(press_pend), 32'hC);
    key_in = 4'hF;
    tick(18);
    pend_clr = 4'hF;
    tick(1);
    pend_clr = 4'h0;
    tick(2);
    check_all("rst_idle", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);

`ifdef KEY_LONG_PRESS_EN
    // 60-cycle hold: one long event exactly 40 cycles after key_state rises.
    key_in = 4'hE;
    tick(57);
    check("long_before", 32'(long_pend), 32'h0);
    tick(1);
    check("long_set", 32'(long_pend), 32'h1);
    check("long_ks", 32'(key_state), 32'h1);
    pend_clr = 4'h1;
    tick(1);
    pend_clr = 4'h0;
    check("long_clr", 32'(long_pend), 32'h0);
    tick(1);
    key_in = 4'hF;
    tick(25);
    check("long_once", 32'(long_pend), 32'h0);
    check("long_released", 32'(key_state), 32'h0);
    pend_clr = 4'hF;
    tick(1);
    pend_clr = 4'h0;
    key_in = 4'hE;
    tick(30);
    key_in = 4'hF;
    tick(40);
    check("short_no_long", 32'(long_pend), 32'h0);
    check("short_pp", 32'(press_pend), 32'h1);
    check("short_rp", 32'(release_pend), 32'h1);
`else
    key_in = 4'hE;
    tick(70);
    check("nolong_lp", 32'(long_pend), 32'h0);
    check("nolong_ks", 32'(key_state), 32'h1);
    key_in = 4'hF;
    tick(20);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_key_input.md
Name: gpio_key_input

Overview:
Input-direction companion to the PS GPIO output path that drives the board LEDs. It takes raw board push-buttons and switches, then synchronizes, debounces and polarity-normalizes them. The stable key levels go to the PS GPIO input bus. Press and release events are latched as sticky pending bits, and a level interrupt is raised toward the PS IRQ_F2P line. Sits in the PL top wrapper between the key pins and the system block design.

Parameters:
KEY_NUM, 4, number of key inputs (1..32)
DEBOUNCE_CYCLES, 1000000, clock cycles a new level must hold before it is accepted (20 ms at 50 MHz); legal range >= 2
KEY_ACTIVE_LOW, 1, 1 = pin reads 0 when pressed; 0 = pin reads 1 when pressed
LONG_CYCLES, 50000000, stable-pressed cycles for a long-press event; used only with KEY_LONG_PRESS_EN

Ports:
clk  input  1  fabric clock (FCLK_CLK0 domain)
rst_n  input  1  asynchronous active-low reset
key_in  input  KEY_NUM  raw key pins, asynchronous to clk
pend_clr  input  KEY_NUM  one-cycle write-1-to-clear pulses from PS GPIO output; bit i clears all pending bits of key i
irq_en  input  KEY_NUM  per-key interrupt enable
key_state  output  KEY_NUM  debounced level, 1 = pressed (to GPIO_tri_i)
press_pend  output  KEY_NUM  sticky press-event flags
release_pend  output  KEY_NUM  sticky release-event flags
long_pend  output  KEY_NUM  sticky long-press flags
irq  output  1  level interrupt to PS

Behaviour:
- Reset (async assert, sync release): all sync flops load the inactive pin level. key_state, press_pend, release_pend, long_pend, irq and all counters are 0.
- Normalize: pressed = key_in XOR KEY_ACTIVE_LOW. Sync through 2 flops per key.
- Debounce, per key, with counter width $clog2(DEBOUNCE_CYCLES):
  - sync == key_state: counter held at 0.
  - sync != key_state: counter increments each cycle.
  - On the edge where the counter equals DEBOUNCE_CYCLES-1 and the mismatch persists, key_state toggles and the counter returns to 0.
  - Any return to agreement before that edge zeroes the counter; the glitch is discarded.
  - Latency from a key_in edge to a key_state change is exactly DEBOUNCE_CYCLES+2 cycles.
- Events:
  - A key_state 0->1 sets press_pend[i] on the same edge key_state updates.
  - A key_state 1->0 sets release_pend[i] on the same edge key_state updates.
  - Flags hold until cleared. Repeated events while a flag is already set are coalesced (no counting).
- Clear: pend_clr[i]=1 clears press_pend[i], release_pend[i] and long_pend[i] on the next edge.
  - Simultaneous set and clear on the same key: set wins, so the flag is 1 afterwards.
  - pend_clr held high for several cycles clears each cycle, but a set still wins.
- irq: registered OR over i of (press_pend[i] | release_pend[i] | long_pend[i]) & irq_en[i].
  - irq asserts one cycle after a pending bit sets and deasserts one cycle after the last enabled pending bit clears.
  - irq_en change takes effect with 1-cycle latency; pending bits are unaffected by irq_en.
- Reset mid-debounce: the count is lost. A key held through reset is reported as a fresh press DEBOUNCE_CYCLES+2 cycles after rst_n release.
- Keys are fully independent; simultaneous events on multiple keys are all latched in the same cycle.

Optional Feature:
KEY_LONG_PRESS_EN
- Defined:
  - A per-key hold counter (width $clog2(LONG_CYCLES+1)) increments while key_state[i]=1.
  - On reaching LONG_CYCLES it sets long_pend[i] once and saturates.
  - It resets to 0 when key_state[i]=0, so there is one long event per press.
  - A short press (release before LONG_CYCLES) produces only press and release events.
- Undefined: long_pend is tied to 0, no hold counters are built, and LONG_CYCLES is ignored.

Test Plan:
1. KEY_NUM=4, DEBOUNCE_CYCLES=16, KEY_ACTIVE_LOW=1. Drive key_in[0] 1->0 and hold -> key_state[0]=1 exactly 18 cycles later; press_pend[0]=1 on the same edge; irq=1 one cycle later with irq_en=4'hF.
2. Glitch: key_in[1] low for 15 cycles, then high -> key_state, press_pend and irq stay 0. A 16-cycle low pulse -> press after 18 cycles; release_pend[1] sets 18 cycles after the rising edge.
3. Clear race: pend_clr[0] pulsed on the same edge a new press sets press_pend[0] -> press_pend[0]=1. pend_clr[0] one cycle later -> 0, and irq drops the following cycle.
4. irq_en=4'b0001 with press_pend[2]=1 -> irq=0. Then irq_en=4'b0100 -> irq=1 one cycle later.
5. Reset asserted at counter value 10 with key_in[3] held pressed -> all outputs 0 immediately. After release, press_pend[3] sets 18 cycles later.
6. With KEY_LONG_PRESS_EN and LONG_CYCLES=40: a 60-cycle hold -> long_pend[0]=1 exactly once, 40 cycles after key_state rises. A 30-cycle hold -> long_pend stays 0.
